imm_decode_stage: RTL

Parametrised, registered immediate-generation stage for the decode slot of the five-stage pipeline. It classifies the 32-bit instruction from its own opcode, extracts the immediate and sign- or zero-extends it to `XLEN`. Results pass through a 2-entry skid buffer with valid/ready handshakes on both sides, so fetch and execute are decoupled and `in_ready` is a register output. It adds XLEN 32/64 selection, RV64 W-op shift handling, an illegal-format flag and pipeline flush.

---
 rtl/imm_pkg.sv | 41 ++++
 rtl/imm_extract.sv | 101 ++++++++++
 rtl/imm_decode_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the decode-slot immediate generator.
// Contents: RISC-V major opcodes, format codes reported on out_fmt,
// shift funct3 values, skid-buffer occupancy states and a shift classifier.
package imm_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_R     = 3'd1;
    localparam logic [2:0] FMT_I     = 3'd2;
    localparam logic [2:0] FMT_S     = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;
    localparam logic [2:0] FMT_U     = 3'd5;
    localparam logic [2:0] FMT_J     = 3'd6;
    localparam logic [2:0] FMT_SHAMT = 3'd7;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    // Skid-buffer occupancy
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRX);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for one 32-bit instruction.
// Ports:
//   instr   - raw instruction
//   imm     - immediate sign-/zero-extended to XLEN
//   fmt     - format code (FMT_*)
//   illegal - unknown opcode or illegal shift amount
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] raw;     // immediate as a 32-bit two's-complement value
    logic [31:0] i_imm;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};

    always_comb begin
        raw     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt = FMT_I;
                raw = i_imm;
            end
            OPC_OP_IMM: begin
                if (is_shift(funct3)) begin
                    fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        raw = {26'b0, instr[25:20]};
                    end else if (instr[25]) begin
                        illegal = 1'b1;
                    end else begin
                        raw = {27'b0, instr[24:20]};
                    end
                end else begin
                    fmt = FMT_I;
                    raw = i_imm;
                end
            end
            OPC_OP_IMM32: begin
                // W-ops do not exist on RV32: the whole opcode is unknown there
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else if (is_shift(funct3)) begin
                    fmt = FMT_SHAMT;
                    if (instr[25]) begin
                        illegal = 1'b1;
                    end else begin
                        raw = {27'b0, instr[24:20]};
                    end
                end else begin
                    fmt = FMT_I;
                    raw = i_imm;
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                raw = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt = FMT_J;
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP, OPC_OP32: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Shift amounts keep raw[31]=0, so one sign-extension covers every format
    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){raw[31]}}, raw};
        end else begin : g_narrow
            assign imm = raw;
        end
    endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_instr/in_pc        - upstream handshake, in_ready registered
//   out_valid/out_ready                     - downstream handshake
//   out_imm/out_fmt/out_illegal             - decoded immediate of the head entry
//   out_instr/out_pc                        - forwarded instruction and PC
//
// state     | meaning
// ----------+---------------------------------------------
// CNT_EMPTY | no entry held, out_valid=0
// CNT_ONE   | head registers hold one entry
// CNT_FULL  | head plus skid registers hold two entries
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    logic [XLEN-1:0] x_imm;
    logic [2:0]      x_fmt;
    logic            x_illegal;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .imm     (x_imm),
        .fmt     (x_fmt),
        .illegal (x_illegal)
    );

    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       push;
    logic       pop;
    logic       load_head_in;
    logic       load_head_skid;
    logic       load_skid;

    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_illegal;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    always_comb begin
        push           = in_valid & in_ready;
        pop            = out_valid & out_ready;
        cnt_nxt        = cnt;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            cnt_nxt = CNT_EMPTY;
        end else begin
            case (cnt)
                CNT_EMPTY: begin
                    if (push) begin
                        cnt_nxt      = CNT_ONE;
                        load_head_in = 1'b1;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        load_head_in = 1'b1;
                    end else if (push) begin
                        cnt_nxt   = CNT_FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        cnt_nxt = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        cnt_nxt        = CNT_ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: begin
                    cnt_nxt = CNT_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= CNT_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            cnt       <= cnt_nxt;
            out_valid <= (cnt_nxt != CNT_EMPTY);
            in_ready  <= (cnt_nxt != CNT_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_imm     <= '0;
            out_fmt     <= FMT_NONE;
            out_illegal <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
        end else if (load_head_in) begin
            out_imm     <= x_imm;
            out_fmt     <= x_fmt;
            out_illegal <= x_illegal;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
        end else if (load_head_skid) begin
            out_imm     <= skid_imm;
            out_fmt     <= skid_fmt;
            out_illegal <= skid_illegal;
            out_instr   <= skid_instr;
            out_pc      <= skid_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
        end else if (load_skid) begin
            skid_imm     <= x_imm;
            skid_fmt     <= x_fmt;
            skid_illegal <= x_illegal;
            skid_instr   <= in_instr;
            skid_pc      <= in_pc;
        end
    end

endmodule
